vector_exec_pipeline: RTL

Parametrised multi-lane execute stage for the 24-bit processor family. It replaces the single combinational scalar ALU with a LANES-wide, STAGES-deep pipelined ALU that supports vector (V=1) and scalar (V=0) operations. Flow control is valid/ready with a global stall, and a flush input squashes in-flight ops. It sits between the register-file read and the memory/writeback stages. It returns lane-0 NZCV flags to the control unit and keeps a retired-op counter.

---
 rtl/vector_exec_pipeline.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vector_exec_pipeline.sv
// rtl/vector_exec_pipeline.sv - LANES-wide, STAGES-deep pipelined ALU execute stage
//
// Purpose: computes a per-lane ALU result combinationally at the input, then
// carries result, tag, vector bit, lane-0 NZCV flags and per-lane zero mask
// through STAGES registers. Valid/ready flow control with a global stall,
// flush squashes in-flight ops, and a 16-bit counter tracks handed-off results.
//
// Optional feature macro: SATURATE_EN (add/sub clamp to the signed N-bit range).
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   flush                    squash every in-flight op on the next edge
//   in_valid / in_ready      input handshake
//   in_v, in_op, in_tag      vector/scalar select, ALU opcode, destination tag
//   in_a, in_b               operands, lane i at [i*N +: N]
//   out_valid / out_ready    output handshake
//   out_data, out_tag, out_v result lanes, tag and vector bit of the result
//   out_flags                {N,Z,C,V} of lane 0
//   out_zero_mask            bit i set when lane i result is zero
//   retired_count            results handed off, wraps at 16 bits

module vector_exec_pipeline #(
    parameter int N      = 24,
    parameter int LANES  = 4,
    parameter int STAGES = 3,
    parameter int TAGW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_v,
    input  logic [2:0]           in_op,
    input  logic [TAGW-1:0]      in_tag,
    input  logic [N*LANES-1:0]   in_a,
    input  logic [N*LANES-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*LANES-1:0]   out_data,
    output logic [TAGW-1:0]      out_tag,
    output logic                 out_v,
    output logic [3:0]           out_flags,
    output logic [LANES-1:0]     out_zero_mask,
    output logic [15:0]          retired_count
);

    localparam int W = N * LANES;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;

    // Wrapping per-lane ALU; shift amount is B[4:0].
    function automatic logic [N-1:0] lane_alu(input logic [2:0] op,
                                              input logic [N-1:0] a,
                                              input logic [N-1:0] b);
        logic [N-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SHL:  r = a << b[4:0];
            OP_SHR:  r = a >> b[4:0];
            default: r = b;
        endcase
        return r;
    endfunction

    // Signed overflow of add/sub, derived from the operand and raw result sign bits.
    function automatic logic add_sub_ovf(input logic [2:0] op,
                                         input logic       a_msb,
                                         input logic       b_msb,
                                         input logic       r_msb);
        logic ovf;
        case (op)
            OP_ADD:  ovf = (a_msb == b_msb) && (r_msb != a_msb);
            OP_SUB:  ovf = (a_msb != b_msb) && (r_msb != a_msb);
            default: ovf = 1'b0;
        endcase
        return ovf;
    endfunction

    // ------------------------------------------------------------------
    // Combinational compute at the input
    // ------------------------------------------------------------------
    logic [N-1:0] lane_raw [LANES];
    logic [N-1:0] lane_res [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_raw[g] = lane_alu(in_op, in_a[g*N +: N], in_b[g*N +: N]);
`ifdef SATURATE_EN
        // On overflow the true result lies beyond the range on the side of A's sign.
        assign lane_res[g] =
            add_sub_ovf(in_op, in_a[g*N+N-1], in_b[g*N+N-1], lane_raw[g][N-1])
                ? (in_a[g*N+N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                : lane_raw[g];
`else
        assign lane_res[g] = lane_raw[g];
`endif
    end

    logic [N-1:0]     a0;
    logic [N-1:0]     b0;
    logic             c0;
    logic             v0;
    logic [W-1:0]     res_data;
    logic [LANES-1:0] res_zmask;
    logic [3:0]       res_flags;

    assign a0 = in_a[N-1:0];
    assign b0 = in_b[N-1:0];

    always_comb begin
        // Add carry-out from the msb column: majority of a, b and the carry into
        // that column, where the carry-in equals the inverted raw sum bit when a!=b.
        c0 = 1'b0;
        if (in_op == OP_ADD) begin
            c0 = (a0[N-1] & b0[N-1]) | ((a0[N-1] | b0[N-1]) & ~lane_raw[0][N-1]);
        end else if (in_op == OP_SUB) begin
            c0 = (a0 >= b0);
        end
        v0 = add_sub_ovf(in_op, a0[N-1], b0[N-1], lane_raw[0][N-1]);
        res_flags = {lane_res[0][N-1], (lane_res[0] == '0), c0, v0};
    end

    always_comb begin
        res_data  = '0;
        res_zmask = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i == 0 || in_v) begin
                res_data[i*N +: N] = lane_res[i];
                res_zmask[i]       = (lane_res[i] == '0);
            end else begin
                // Scalar op: upper lanes read as zero and are flagged zero.
                res_data[i*N +: N] = '0;
                res_zmask[i]       = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] v_q, v_d;
    logic [W-1:0]      data_q  [STAGES];
    logic [W-1:0]      data_d  [STAGES];
    logic [TAGW-1:0]   tag_q   [STAGES];
    logic [TAGW-1:0]   tag_d   [STAGES];
    logic [3:0]        flags_q [STAGES];
    logic [3:0]        flags_d [STAGES];
    logic [LANES-1:0]  zmask_q [STAGES];
    logic [LANES-1:0]  zmask_d [STAGES];
    logic [15:0]       retired_q, retired_d;

    logic advance;
    logic accept;
    logic handoff;

    // The whole pipe moves in lockstep: a stalled output freezes every stage,
    // so bubbles are never squeezed out.
    assign advance  = out_ready | ~valid_q[STAGES-1];
    assign in_ready = advance & ~flush & ~rst;
    assign accept   = in_valid & in_ready;
    assign handoff  = valid_q[STAGES-1] & out_ready;

    always_comb begin
        valid_d = valid_q;
        v_d     = v_q;
        for (int s = 0; s < STAGES; s++) begin
            data_d[s]  = data_q[s];
            tag_d[s]   = tag_q[s];
            flags_d[s] = flags_q[s];
            zmask_d[s] = zmask_q[s];
        end

        if (advance) begin
            valid_d[0] = accept;
            v_d[0]     = in_v;
            data_d[0]  = res_data;
            tag_d[0]   = in_tag;
            flags_d[0] = res_flags;
            zmask_d[0] = res_zmask;
            for (int s = 1; s < STAGES; s++) begin
                valid_d[s] = valid_q[s-1];
                v_d[s]     = v_q[s-1];
                data_d[s]  = data_q[s-1];
                tag_d[s]   = tag_q[s-1];
                flags_d[s] = flags_q[s-1];
                zmask_d[s] = zmask_q[s-1];
            end
        end

        // Flush only kills valid bits; payload registers may hold stale values.
        if (flush) begin
            valid_d = '0;
        end

        // A result leaving in the flush cycle is still a real handoff.
        retired_d = retired_q + {15'b0, handoff};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            v_q       <= '0;
            retired_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s]  <= '0;
                tag_q[s]   <= '0;
                flags_q[s] <= '0;
                zmask_q[s] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            v_q       <= v_d;
            retired_q <= retired_d;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s]  <= data_d[s];
                tag_q[s]   <= tag_d[s];
                flags_q[s] <= flags_d[s];
                zmask_q[s] <= zmask_d[s];
            end
        end
    end

    assign out_valid     = valid_q[STAGES-1];
    assign out_data      = data_q[STAGES-1];
    assign out_tag       = tag_q[STAGES-1];
    assign out_v         = v_q[STAGES-1];
    assign out_flags     = flags_q[STAGES-1];
    assign out_zero_mask = zmask_q[STAGES-1];
    assign retired_count = retired_q;

endmodule
